// File: rtl/tpu_skew_feed_ctrl.sv
// Operand tile feeder: issues DEPTH row reads from the operand buffer, then skews the
// rows so that lane k reaches the systolic array k cycles after lane 0.
module tpu_skew_feed_ctrl #(
  parameter int unsigned DATA_WIDTH = 18,
  parameter int unsigned LANES      = 4,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned ADDR_WIDTH = 3
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          hold,
  output logic                          busy,
  output logic                          done,
  output logic                          rd_en,
  output logic [ADDR_WIDTH-1:0]         rd_addr,
  input  logic [LANES*DATA_WIDTH-1:0]   rd_data,
  output logic [LANES*DATA_WIDTH-1:0]   out_data,
  output logic [LANES-1:0]              out_valid
);

  localparam int unsigned DCW = $clog2(LANES + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t          state;
  logic [DCW-1:0]  drain_cnt;
  logic            rd_pend;

  // Read strobe follows hold in the same cycle so a stalled row keeps its address.
  assign rd_en = (state == FETCH) && !hold;

  // Tile sequencer; rd_addr doubles as the issued-row counter and wraps to 0 after the last row.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      rd_addr   <= '0;
      drain_cnt <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state   <= FETCH;
            busy    <= 1'b1;
            rd_addr <= '0;
          end
        end
        FETCH: begin
          if (!hold) begin
            if (rd_addr == ADDR_WIDTH'(DEPTH - 1)) begin
              rd_addr   <= '0;
              drain_cnt <= '0;
              state     <= DRAIN;
            end else begin
              rd_addr <= rd_addr + ADDR_WIDTH'(1);
            end
          end
        end
        DRAIN: begin
          if (drain_cnt == DCW'(LANES)) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + DCW'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Buffer returns data one cycle after the strobe; this tags that cycle as valid.
  always_ff @(posedge clk) begin
    if (reset) rd_pend <= 1'b0;
    else       rd_pend <= rd_en;
  end

  // Per-lane delay chains: stage 0 captures the row (zeroed when not valid), lane k adds k stages.
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [k:0]            v;
    logic [DATA_WIDTH-1:0] d [k+1];

    always_ff @(posedge clk) begin
      if (reset) begin
        v <= '0;
        for (int j = 0; j <= k; j++) d[j] <= '0;
      end else begin
        v[0] <= rd_pend;
        d[0] <= rd_pend ? rd_data[k*DATA_WIDTH +: DATA_WIDTH] : '0;
        for (int j = 1; j <= k; j++) begin
          v[j] <= v[j-1];
          d[j] <= d[j-1];
        end
      end
    end

    assign out_valid[k]                          = v[k];
    assign out_data[k*DATA_WIDTH +: DATA_WIDTH]  = d[k];
  end

endmodule

// File: tb/tb_tpu_skew_feed_ctrl.sv
// Bench for tpu_skew_feed_ctrl: tile-level reference schedule, spot-check table, and a DEPTH=1 build.
module tb_tpu_skew_feed_ctrl;

  localparam int unsigned DW    = 18;
  localparam int unsigned LN    = 4;
  localparam int unsigned DP    = 4;
  localparam int unsigned AW    = 2;
  localparam int unsigned ROW_W = LN * DW;
  localparam int          NCYC  = 48;
  localparam int          NMAX  = 64;

  localparam int K_BUSY  = 0;
  localparam int K_DONE  = 1;
  localparam int K_RDEN  = 2;
  localparam int K_ADDR  = 3;
  localparam int K_VALID = 4;
  localparam int K_DATA  = 5;

  logic             clk = 1'b0;
  logic             reset, start, hold, start1;
  logic             busy, done, rd_en;
  logic [AW-1:0]    rd_addr;
  logic [ROW_W-1:0] rd_data, out_data;
  logic [LN-1:0]    out_valid;

  logic             busy1, done1, rd_en1;
  logic [0:0]       rd_addr1;
  logic [ROW_W-1:0] rd_data1, out_data1;
  logic [LN-1:0]    out_valid1;

  always #5 clk = ~clk;

  tpu_skew_feed_ctrl #(.DATA_WIDTH(DW), .LANES(LN), .DEPTH(DP), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .hold(hold), .busy(busy), .done(done),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .out_data(out_data),
    .out_valid(out_valid)
  );

  tpu_skew_feed_ctrl #(.DATA_WIDTH(DW), .LANES(LN), .DEPTH(1), .ADDR_WIDTH(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .hold(1'b0), .busy(busy1), .done(done1),
    .rd_en(rd_en1), .rd_addr(rd_addr1), .rd_data(rd_data1), .out_data(out_data1),
    .out_valid(out_valid1)
  );

  logic [DW-1:0] mem [DP][LN];

  // Operand buffer models: one-cycle read latency, junk on the bus when not reading.
  always @(posedge clk) begin
    for (int k = 0; k < LN; k++)
      rd_data[k*DW +: DW] <= rd_en ? mem[rd_addr][k] : DW'($urandom);
  end
  always @(posedge clk) begin
    for (int k = 0; k < LN; k++)
      rd_data1[k*DW +: DW] <= rd_en1 ? DW'(k) : DW'($urandom);
  end

  int checks = 0;
  int passes = 0;

  task automatic chk(input string nm, input int c, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s cycle=%0d got=%0h expected=%0h", nm, c, act, exp);
  endtask

  bit            start_v [NMAX];
  bit            hold_v  [NMAX];
  bit            reset_v [NMAX];
  bit            exp_busy[NMAX];
  bit            exp_done[NMAX];
  bit            exp_rden[NMAX];
  int            exp_addr[NMAX];
  bit            exp_v   [NMAX][LN];
  logic [DW-1:0] exp_d   [NMAX][LN];

  typedef struct {
    int scen;
    int cyc;
    int kind;
    int lane;
    int val;
  } spot_t;
  spot_t spots[$];

  task automatic clear_exp_from(input int first);
    for (int i = first; i < NMAX; i++) begin
      exp_busy[i] = 0; exp_done[i] = 0; exp_rden[i] = 0; exp_addr[i] = 0;
      for (int k = 0; k < LN; k++) begin exp_v[i][k] = 0; exp_d[i][k] = '0; end
    end
  endtask

  // Tile-level schedule: rows go out when hold is low, lane k shows row at issue+2+k,
  // then LANES+1 drain cycles, done on the following (idle) cycle.
  task automatic build_model();
    int idle_from, t, r;
    clear_exp_from(0);
    idle_from = 0;
    for (int c = 0; c < NCYC; c++) begin
      if (reset_v[c]) begin
        clear_exp_from(c + 1);
        idle_from = c + 1;
      end else if (start_v[c] && c >= idle_from) begin
        t = c + 1;
        r = 0;
        while (r < DP && t < NMAX) begin
          exp_busy[t] = 1;
          exp_addr[t] = r;
          if (!hold_v[t]) begin
            exp_rden[t] = 1;
            for (int k = 0; k < LN; k++)
              if (t + 2 + k < NMAX) begin
                exp_v[t+2+k][k] = 1;
                exp_d[t+2+k][k] = mem[r][k];
              end
            r++;
          end
          t++;
        end
        for (int i = 0; i <= LN; i++) if (t + i < NMAX) exp_busy[t+i] = 1;
        if (t + LN + 1 < NMAX) exp_done[t+LN+1] = 1;
        idle_from = t + LN + 1;
      end
    end
  endtask

  task automatic set_scen(input int s);
    for (int c = 0; c < NMAX; c++) begin start_v[c] = 0; hold_v[c] = 0; reset_v[c] = 0; end
    for (int r = 0; r < DP; r++)
      for (int k = 0; k < LN; k++)
        mem[r][k] = (s < 4) ? DW'(16 * r + k) : DW'($urandom);
    case (s)
      0: start_v[0] = 1;
      1: begin start_v[0] = 1; hold_v[3] = 1; hold_v[4] = 1; end
      2: begin start_v[0] = 1; start_v[5] = 1; start_v[10] = 1; end
      3: begin start_v[0] = 1; reset_v[7] = 1; end
      default:
        for (int c = 0; c < NCYC; c++) begin
          start_v[c] = ($urandom_range(0, 4) == 0);
          hold_v[c]  = ($urandom_range(0, 9) < 3);
          reset_v[c] = ($urandom_range(0, 39) == 0);
        end
    endcase
  endtask

  function automatic logic [31:0] act_of(input int kind, input int lane);
    case (kind)
      K_BUSY:  return 32'(busy);
      K_DONE:  return 32'(done);
      K_RDEN:  return 32'(rd_en);
      K_ADDR:  return 32'(rd_addr);
      K_VALID: return 32'(out_valid[lane]);
      default: return 32'(out_data[lane*DW +: DW]);
    endcase
  endfunction

  task automatic apply_reset();
    reset = 1; start = 0; hold = 0; start1 = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy",  -1, 32'(busy),      32'(0));
    chk("rst_done",  -1, 32'(done),      32'(0));
    chk("rst_rd_en", -1, 32'(rd_en),     32'(0));
    chk("rst_valid", -1, 32'(out_valid), 32'(0));
    chk("rst_data",  -1, 32'(out_data == '0), 32'(1));
    @(posedge clk); #1;
  endtask

  task automatic run_scen(input int s);
    set_scen(s);
    build_model();
    apply_reset();
    for (int c = 0; c < NCYC; c++) begin
      reset = reset_v[c];
      start = start_v[c];
      hold  = hold_v[c];
      @(negedge clk);
      chk("busy",  c, 32'(busy),  32'(exp_busy[c]));
      chk("done",  c, 32'(done),  32'(exp_done[c]));
      chk("rd_en", c, 32'(rd_en), 32'(exp_rden[c]));
      if (exp_rden[c]) chk("rd_addr", c, 32'(rd_addr), 32'(exp_addr[c]));
      for (int k = 0; k < LN; k++) begin
        chk($sformatf("s%0d_valid%0d", s, k), c, 32'(out_valid[k]), 32'(exp_v[c][k]));
        chk($sformatf("s%0d_data%0d", s, k), c, 32'(out_data[k*DW +: DW]), 32'(exp_d[c][k]));
      end
      foreach (spots[i])
        if (spots[i].scen == s && spots[i].cyc == c)
          chk($sformatf("spot%0d", i), c, act_of(spots[i].kind, spots[i].lane), 32'(spots[i].val));
      @(posedge clk); #1;
    end
  endtask

  initial begin
    // Hand-derived checkpoints (DEPTH=4, row r lane k = 16r+k).
    spots.push_back('{0,  0, K_BUSY,  0, 0});
    spots.push_back('{0,  1, K_RDEN,  0, 1});
    spots.push_back('{0,  1, K_ADDR,  0, 0});
    spots.push_back('{0,  4, K_ADDR,  0, 3});
    spots.push_back('{0,  5, K_RDEN,  0, 0});
    spots.push_back('{0,  3, K_VALID, 0, 1});
    spots.push_back('{0,  6, K_DATA,  0, 48});
    spots.push_back('{0,  8, K_DATA,  3, 35});
    spots.push_back('{0,  9, K_DATA,  3, 51});
    spots.push_back('{0,  9, K_BUSY,  0, 1});
    spots.push_back('{0,  9, K_DONE,  0, 0});
    spots.push_back('{0, 10, K_DONE,  0, 1});
    spots.push_back('{0, 10, K_BUSY,  0, 0});
    spots.push_back('{1,  3, K_RDEN,  0, 0});
    spots.push_back('{1,  4, K_ADDR,  0, 2});
    spots.push_back('{1,  5, K_RDEN,  0, 1});
    spots.push_back('{1,  5, K_ADDR,  0, 2});
    spots.push_back('{1,  6, K_ADDR,  0, 3});
    spots.push_back('{1,  5, K_VALID, 0, 0});
    spots.push_back('{1,  6, K_VALID, 0, 0});
    spots.push_back('{1,  7, K_DATA,  0, 32});
    spots.push_back('{1,  8, K_VALID, 3, 0});
    spots.push_back('{1, 10, K_DATA,  3, 35});
    spots.push_back('{1, 11, K_BUSY,  0, 1});
    spots.push_back('{1, 12, K_DONE,  0, 1});
    spots.push_back('{2,  6, K_RDEN,  0, 0});
    spots.push_back('{2, 11, K_RDEN,  0, 1});
    spots.push_back('{2, 11, K_ADDR,  0, 0});
    spots.push_back('{2, 19, K_DATA,  3, 51});
    spots.push_back('{2, 20, K_DONE,  0, 1});
    spots.push_back('{3,  7, K_BUSY,  0, 1});
    spots.push_back('{3,  8, K_BUSY,  0, 0});
    spots.push_back('{3,  8, K_VALID, 3, 0});
    spots.push_back('{3, 10, K_DONE,  0, 0});

    for (int s = 0; s < 10; s++) run_scen(s);

    // Single-row tile build: one read at cycle 1, lane k at 3+k, done at 7.
    apply_reset();
    reset = 0;
    for (int c = 0; c < 10; c++) begin
      start1 = (c == 0);
      @(negedge clk);
      chk("d1_busy",  c, 32'(busy1),  32'(c >= 1 && c <= 6));
      chk("d1_done",  c, 32'(done1),  32'(c == 7));
      chk("d1_rd_en", c, 32'(rd_en1), 32'(c == 1));
      if (c == 1) chk("d1_rd_addr", c, 32'(rd_addr1), 32'(0));
      for (int k = 0; k < LN; k++) begin
        chk($sformatf("d1_valid%0d", k), c, 32'(out_valid1[k]), 32'(c == 3 + k));
        chk($sformatf("d1_data%0d", k), c, 32'(out_data1[k*DW +: DW]), (c == 3 + k) ? 32'(k) : 32'(0));
      end
      @(posedge clk); #1;
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
